// File: rtl/me_host.sv
// Frame-load front end and result collector for the me_double motion-estimation core.
// Buffers one target block plus search window and serves the core's read ports.
`timescale 1ns/1ps
module me_host #(
   parameter int TB_DEPTH = 64,
   parameter int SW_DEPTH = 1024,
   parameter int TIMEOUT  = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_data,
   output logic        req,
   input  logic        ack,
   input  logic [15:0] min_sad,
   input  logic [9:0]  min_mvec,
   input  logic [5:0]  addr_tb,
   input  logic [9:0]  addr_sw,
   output logic [31:0] pel_tb,
   output logic [31:0] pel_sw,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_sad,
   output logic [9:0]  res_mvec,
   output logic        res_err,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, LOAD_TB, LOAD_SW, REQ, RESULT} state_t;

   localparam logic [9:0]  TB_LAST  = 10'(TB_DEPTH - 1);
   localparam logic [9:0]  SW_LAST  = 10'(SW_DEPTH - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state_reg, state_next;
   logic [9:0]  wptr_reg, wptr_next;
   logic [15:0] tmo_reg, tmo_next;
   logic        ready_en_reg;
   logic [15:0] res_sad_reg;
   logic [9:0]  res_mvec_reg;
   logic        res_err_reg;
   logic [31:0] pel_tb_reg, pel_sw_reg;

   logic [31:0] tb_mem [TB_DEPTH];
   logic [31:0] sw_mem [SW_DEPTH];

   logic ld_fire;
   logic tb_we, sw_we;
   logic ack_take, tmo_hit;

   assign ld_fire  = ld_valid & ld_ready;
   assign tb_we    = ld_fire & ((state_reg == IDLE) | (state_reg == LOAD_TB));
   assign sw_we    = ld_fire & (state_reg == LOAD_SW);
   assign ack_take = (state_reg == REQ) & ack;
   assign tmo_hit  = (state_reg == REQ) & ~ack & (tmo_reg == TMO_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         wptr_reg     <= '0;
         tmo_reg      <= '0;
         ready_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wptr_reg     <= wptr_next;
         tmo_reg      <= tmo_next;
         ready_en_reg <= 1'b1;
      end
   end

   // Next-state logic; wptr is zero whenever IDLE is entered, so IDLE writes land in tb[0]
   always_comb begin
      state_next = state_reg;
      wptr_next  = wptr_reg;
      tmo_next   = tmo_reg;
      unique case (state_reg)
         IDLE: begin
            if (ld_fire) begin
               state_next = LOAD_TB;
               wptr_next  = 10'd1;
            end
         end
         LOAD_TB: begin
            if (ld_fire) begin
               if (wptr_reg == TB_LAST) begin
                  state_next = LOAD_SW;
                  wptr_next  = '0;
               end else begin
                  wptr_next = wptr_reg + 10'd1;
               end
            end
         end
         LOAD_SW: begin
            if (ld_fire) begin
               if (wptr_reg == SW_LAST) begin
                  state_next = REQ;
                  wptr_next  = '0;
                  tmo_next   = '0;
               end else begin
                  wptr_next = wptr_reg + 10'd1;
               end
            end
         end
         REQ: begin
            if (ack_take || tmo_hit) begin
               state_next = RESULT;
            end else begin
               tmo_next = tmo_reg + 16'd1;
            end
         end
         RESULT: begin
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode; ld_ready is held low until the first clock after reset release
   always_comb begin
      ld_ready  = 1'b0;
      req       = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_reg)
         IDLE:    begin ld_ready = ready_en_reg; busy = 1'b0; end
         LOAD_TB: ld_ready = ready_en_reg;
         LOAD_SW: ld_ready = ready_en_reg;
         REQ:     req = 1'b1;
         RESULT:  res_valid = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_sad_reg  <= '0;
         res_mvec_reg <= '0;
         res_err_reg  <= 1'b0;
      end else if (ack_take) begin
         res_sad_reg  <= min_sad;
         res_mvec_reg <= min_mvec;
         res_err_reg  <= 1'b0;
      end else if (tmo_hit) begin
         res_err_reg  <= 1'b1;
      end
   end

   // Frame buffers: contents survive reset
   always_ff @(posedge clk) begin
      if (tb_we) begin
         tb_mem[wptr_reg[5:0]] <= ld_data;
      end
      if (sw_we) begin
         sw_mem[wptr_reg] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pel_tb_reg <= '0;
         pel_sw_reg <= '0;
      end else begin
         pel_tb_reg <= tb_mem[addr_tb];
         pel_sw_reg <= sw_mem[addr_sw];
      end
   end

   assign pel_tb   = pel_tb_reg;
   assign pel_sw   = pel_sw_reg;
   assign res_sad  = res_sad_reg;
   assign res_mvec = res_mvec_reg;
   assign res_err  = res_err_reg;

endmodule

// File: tb/tb_me_host.sv
// Directed self-checking bench for me_host: load, readback, ack capture,
// result hold, timeout (TIMEOUT=100) and reset during a load.
`timescale 1ns/1ps
module tb_me_host;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [31:0] ld_data = '0;
   logic        req;
   logic        ack = 1'b0;
   logic [15:0] min_sad = '0;
   logic [9:0]  min_mvec = '0;
   logic [5:0]  addr_tb = '0;
   logic [9:0]  addr_sw = '0;
   logic [31:0] pel_tb, pel_sw;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_sad;
   logic [9:0]  res_mvec;
   logic        res_err;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   me_host #(.TIMEOUT(100)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .req(req), .ack(ack), .min_sad(min_sad), .min_mvec(min_mvec),
      .addr_tb(addr_tb), .addr_sw(addr_sw), .pel_tb(pel_tb), .pel_sw(pel_sw),
      .res_valid(res_valid), .res_ready(res_ready), .res_sad(res_sad),
      .res_mvec(res_mvec), .res_err(res_err), .busy(busy)
   );

   // Drives beats from negedge; a beat counts when ld_ready is seen with ld_valid high.
   task automatic load_frame(input logic [31:0] tb_base, input logic [31:0] sw_base,
                             input int n_beats, input int gap_every,
                             output int accepted, output logic saw_req);
      int cyc;
      cyc = 0;
      accepted = 0;
      saw_req = 1'b0;
      while (accepted < n_beats && cyc < 4000) begin
         @(negedge clk);
         if (req) saw_req = 1'b1;
         if (gap_every != 0 && (cyc % gap_every) == gap_every - 1) begin
            ld_valid = 1'b0;
         end else begin
            ld_valid = 1'b1;
            ld_data  = (accepted < 64) ? tb_base + 32'(accepted) : sw_base + 32'(accepted - 64);
         end
         if (ld_valid && ld_ready) accepted++;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ld_ready, req, res_valid, busy, res_err} !== 5'b0 || pel_tb !== 32'h0 ||
          pel_sw !== 32'h0 || res_sad !== 16'h0 || res_mvec !== 10'h0) begin
         failures++;
         $display("FAIL reset_outputs: ld_ready=%b req=%b res_valid=%b busy=%b res_err=%b pel_tb=%h pel_sw=%h res_sad=%h res_mvec=%h, required all zero",
                  ld_ready, req, res_valid, busy, res_err, pel_tb, pel_sw, res_sad, res_mvec);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ld_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: ld_ready=%b busy=%b, required ld_ready=1 busy=0", ld_ready, busy);
      end
   endtask

   task automatic test_frame_load();
      int acc;
      logic sr;
      load_frame(32'h0, 32'h0001_0000, 1088, 0, acc, sr);
      @(negedge clk);
      checks++;
      if (acc !== 1088) begin
         failures++;
         $display("FAIL load_count: accepted=%0d, required 1088", acc);
      end
      checks++;
      if (sr !== 1'b0) begin
         failures++;
         $display("FAIL req_during_load: req seen=%b, required 0", sr);
      end
      checks++;
      if (req !== 1'b1 || ld_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL req_latency: req=%b ld_ready=%b busy=%b one cycle after last beat, required 1/0/1", req, ld_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (ld_ready !== 1'b0 || req !== 1'b1) begin
         failures++;
         $display("FAIL ready_low_in_req: ld_ready=%b req=%b, required 0/1", ld_ready, req);
      end
      ld_valid = 1'b0;
   endtask

   task automatic test_read_ports();
      addr_tb = 6'd5;
      #1;
      checks++;
      if (pel_tb !== 32'h0000_0000) begin
         failures++;
         $display("FAIL pel_tb_latency: pel_tb=%h same cycle as address, required 00000000", pel_tb);
      end
      @(negedge clk);
      checks++;
      if (pel_tb !== 32'h0000_0005 || pel_sw !== 32'h0001_0000) begin
         failures++;
         $display("FAIL read_tb5: pel_tb=%h pel_sw=%h, required 00000005 00010000", pel_tb, pel_sw);
      end
      addr_sw = 10'd1023;
      @(negedge clk);
      checks++;
      if (pel_sw !== 32'h0001_03FF) begin
         failures++;
         $display("FAIL read_sw1023: pel_sw=%h, required 000103ff", pel_sw);
      end
   endtask

   task automatic test_ack_capture();
      ack = 1'b1;
      min_sad = 16'h01F4;
      min_mvec = 10'h2A5;
      @(negedge clk);
      checks++;
      if (req !== 1'b0 || res_valid !== 1'b1 || res_sad !== 16'h01F4 || res_mvec !== 10'h2A5 || res_err !== 1'b0) begin
         failures++;
         $display("FAIL ack_capture: req=%b res_valid=%b res_sad=%h res_mvec=%h res_err=%b, required 0 1 01f4 2a5 0",
                  req, res_valid, res_sad, res_mvec, res_err);
      end
      min_sad = 16'hFFFF;
      min_mvec = 10'h3FF;
      repeat (2) @(negedge clk);
      ack = 1'b0;
      checks++;
      if (res_sad !== 16'h01F4 || res_mvec !== 10'h2A5 || req !== 1'b0) begin
         failures++;
         $display("FAIL ack_once: res_sad=%h res_mvec=%h req=%b after held ack, required 01f4 2a5 0", res_sad, res_mvec, req);
      end
   endtask

   task automatic test_result_hold();
      int bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_sad !== 16'h01F4 || res_mvec !== 10'h2A5 ||
             res_err !== 1'b0 || busy !== 1'b1 || ld_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL result_hold: %0d of 10 cycles unstable (res_valid=%b res_sad=%h), required 0", bad, res_valid, res_sad);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL result_handshake: res_valid=%b busy=%b ld_ready=%b, required 0 0 1", res_valid, busy, ld_ready);
      end
   endtask

   task automatic test_ack_ignored();
      ack = 1'b1;
      min_sad = 16'h1234;
      min_mvec = 10'h155;
      repeat (2) @(negedge clk);
      ack = 1'b0;
      checks++;
      if (busy !== 1'b0 || req !== 1'b0 || res_valid !== 1'b0 || res_sad !== 16'h01F4 || res_mvec !== 10'h2A5) begin
         failures++;
         $display("FAIL ack_in_idle: busy=%b req=%b res_valid=%b res_sad=%h res_mvec=%h, required 0 0 0 01f4 2a5",
                  busy, req, res_valid, res_sad, res_mvec);
      end
   endtask

   task automatic test_timeout();
      int acc;
      int n;
      int req_cycles;
      logic sr;
      load_frame(32'hA000_0000, 32'hB000_0000, 1088, 7, acc, sr);
      @(negedge clk);
      ld_valid = 1'b0;
      checks++;
      if (acc !== 1088 || req !== 1'b1) begin
         failures++;
         $display("FAIL gapped_load: accepted=%0d req=%b, required 1088 1", acc, req);
      end
      req_cycles = (req === 1'b1) ? 1 : 0;
      n = 0;
      while (req === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
         if (req === 1'b1) req_cycles++;
      end
      checks++;
      if (req_cycles != 100) begin
         failures++;
         $display("FAIL timeout_len: req high %0d cycles, required 100", req_cycles);
      end
      checks++;
      if (res_valid !== 1'b1 || res_err !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL timeout_result: res_valid=%b res_err=%b busy=%b, required 1 1 1", res_valid, res_err, busy);
      end
      addr_tb = 6'd63;
      addr_sw = 10'd0;
      @(negedge clk);
      checks++;
      if (pel_tb !== 32'hA000_003F || pel_sw !== 32'hB000_0000) begin
         failures++;
         $display("FAIL gapped_readback: pel_tb=%h pel_sw=%h, required a000003f b0000000", pel_tb, pel_sw);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_handshake: res_valid=%b busy=%b, required 0 0", res_valid, busy);
      end
   endtask

   task automatic test_reset_midload();
      int acc;
      logic sr;
      load_frame(32'h5500_0000, 32'h6600_0000, 94, 0, acc, sr);
      @(negedge clk);
      ld_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL partial_load_state: busy=%b ld_ready=%b, required 1 1", busy, ld_ready);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ld_ready, req, res_valid, busy, res_err} !== 5'b0 || pel_tb !== 32'h0 ||
          pel_sw !== 32'h0 || res_sad !== 16'h0 || res_mvec !== 10'h0) begin
         failures++;
         $display("FAIL midload_reset: ld_ready=%b req=%b res_valid=%b busy=%b res_err=%b pel_tb=%h pel_sw=%h res_sad=%h res_mvec=%h, required all zero",
                  ld_ready, req, res_valid, busy, res_err, pel_tb, pel_sw, res_sad, res_mvec);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      load_frame(32'h7700_0000, 32'h8800_0000, 1088, 0, acc, sr);
      @(negedge clk);
      ld_valid = 1'b0;
      checks++;
      if (acc !== 1088 || sr !== 1'b0 || req !== 1'b1) begin
         failures++;
         $display("FAIL reload_after_reset: accepted=%0d early_req=%b req=%b, required 1088 0 1", acc, sr, req);
      end
      addr_tb = 6'd0;
      addr_sw = 10'd29;
      @(negedge clk);
      checks++;
      if (pel_tb !== 32'h7700_0000 || pel_sw !== 32'h8800_001D) begin
         failures++;
         $display("FAIL reload_readback: pel_tb=%h pel_sw=%h, required 77000000 8800001d", pel_tb, pel_sw);
      end
      ack = 1'b1;
      min_sad = 16'h0042;
      min_mvec = 10'h011;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || res_sad !== 16'h0042 || res_mvec !== 10'h011 || res_err !== 1'b0) begin
         failures++;
         $display("FAIL reload_capture: res_valid=%b res_sad=%h res_mvec=%h res_err=%b, required 1 0042 011 0",
                  res_valid, res_sad, res_mvec, res_err);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reload_handshake: res_valid=%b busy=%b, required 0 0", res_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_frame_load();
      test_read_ports();
      test_ack_capture();
      test_result_hold();
      test_ack_ignored();
      test_timeout();
      test_reset_midload();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
